sdram_rw_arbiter: RTL

- Schedules burst traffic into the SDRAM controller for the camera-to-monitor frame buffer.
- Watches the camera write-FIFO level and the monitor read-FIFO level, then raises exactly one of wr_sdram_req / rd_sdram_req and holds it until the matching ack.
- Generates the per-burst SDRAM address and ping-pong buffer selection so the reader never reads the frame currently being written.
- Sits between the camera/monitor FIFOs and the SDRAM controller; runs on the SDRAM clock.

---
 rtl/sdram_rw_arbiter_pkg.sv | 18 +
 rtl/sdram_rw_arbiter_if.sv | 35 +++
 rtl/sdram_rw_arbiter_burst_addr_gen.sv | 63 ++++++
 rtl/sdram_rw_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sdram_rw_arbiter_pkg.sv
// Shared encodings and default constants for the SDRAM read/write burst arbiter.
package sdram_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_BUSY = 2'd1;
    localparam logic [1:0] ST_RD_BUSY = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    // Encoding of the side that received the most recent grant
    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

    // Defaults matching a 640x480 frame carried in 512-word bursts
    localparam int DEF_BURST_LEN    = 512;
    localparam int DEF_FRAME_BURSTS = 600;

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// Bundle of FIFO-level, frame-sync and SDRAM-controller handshake signals seen by the arbiter.
interface sdram_rw_arbiter_if #(
    parameter int FIFO_AW = 11,
    parameter int BCNT_W  = 10
);
    logic               init_done;
    logic [FIFO_AW-1:0] wr_fifo_level;
    logic [FIFO_AW-1:0] rd_fifo_level;
    logic               wr_frame_start;
    logic               rd_frame_start;
    logic               wr_sdram_ack;
    logic               rd_sdram_ack;
    logic               wr_sdram_req;
    logic               rd_sdram_req;
    logic [BCNT_W:0]    wr_burst_addr;
    logic [BCNT_W:0]    rd_burst_addr;
    logic               rd_buf_valid;
    logic               wr_frame_done;

    // The arbiter itself
    modport master (
        input  init_done, wr_fifo_level, rd_fifo_level,
        input  wr_frame_start, rd_frame_start, wr_sdram_ack, rd_sdram_ack,
        output wr_sdram_req, rd_sdram_req, wr_burst_addr, rd_burst_addr,
        output rd_buf_valid, wr_frame_done
    );

    // FIFOs, video timing and SDRAM controller around the arbiter
    modport slave (
        output init_done, wr_fifo_level, rd_fifo_level,
        output wr_frame_start, rd_frame_start, wr_sdram_ack, rd_sdram_ack,
        input  wr_sdram_req, rd_sdram_req, wr_burst_addr, rd_burst_addr,
        input  rd_buf_valid, wr_frame_done
    );
endinterface

// File: rtl/sdram_rw_arbiter_burst_addr_gen.sv
// Per-side burst address generator: burst counter with explicit wrap, ping-pong
// buffer bit, and a frame-start restart that waits for an in-flight burst to finish.
module burst_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int FRAME_BURSTS   = DEF_FRAME_BURSTS,
    parameter int BCNT_W         = 10,
    parameter bit TOGGLE_ON_WRAP = 1'b0,   // write side flips buffers at end of frame
    parameter bit LOAD_ON_START  = 1'b0    // read side jumps to the last completed buffer
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_busy,         // a burst of this side is in flight
    input  logic            i_adv,          // the in-flight burst was acked this cycle
    input  logic            i_frame_start,
    input  logic            i_load_buf,
    output logic [BCNT_W:0] o_addr,
    output logic            o_wrap
);
    localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(FRAME_BURSTS - 1);

    logic [BCNT_W-1:0] r_bcnt;
    logic              r_buf;
    logic              r_pend;
    logic              w_last;
    logic              w_defer;
    logic              w_restart;

    assign w_last    = (r_bcnt == LAST_BURST);
    assign o_wrap    = i_adv && w_last;
    // A frame start that lands mid-burst must not move the address the controller is using
    assign w_defer   = i_frame_start && i_busy && !i_adv;
    assign w_restart = (i_frame_start && (!i_busy || i_adv)) || (i_adv && r_pend);
    assign o_addr    = {r_buf, r_bcnt};

    // Burst counter, buffer bit and deferred frame-start flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt <= '0;
            r_buf  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (w_defer) begin
                r_pend <= 1'b1;
            end else if (i_adv || w_restart) begin
                r_pend <= 1'b0;
            end

            // Restart beats advance, so an ack coinciding with a frame start lands on 0
            if (w_restart) begin
                r_bcnt <= '0;
            end else if (i_adv) begin
                r_bcnt <= w_last ? '0 : r_bcnt + BCNT_W'(1);
            end

            if (LOAD_ON_START && w_restart) begin
                r_buf <= i_load_buf;
            end else if (TOGGLE_ON_WRAP && o_wrap) begin
                r_buf <= ~r_buf;
            end
        end
    end
endmodule

// File: rtl/sdram_rw_arbiter.sv
// Camera/monitor frame-buffer burst scheduler in front of the SDRAM controller.
// Grants one write or read burst at a time, holds it until ack, then idles one cycle.
module sdram_rw_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int FIFO_AW       = 11,
    parameter int RD_FIFO_DEPTH = 1024,
    parameter int FRAME_BURSTS  = DEF_FRAME_BURSTS,
    parameter int BCNT_W        = 10,
    parameter int RD_URGENT     = 128
) (
    input  logic                clk,
    input  logic                rst,
    sdram_rw_arbiter_if.master  bus
);
    logic [1:0]         r_state;
    logic               r_last_grant;
    logic               r_completed_buf;
    logic               r_rd_buf_valid;
    logic               r_wr_frame_done;

    logic [FIFO_AW-1:0] w_wr_level;
    logic [FIFO_AW-1:0] w_rd_level;
    logic               w_wr_elig;
    logic               w_rd_elig;
    logic               w_rd_urgent;
    logic               w_grant_wr;
    logic               w_grant_rd;
    logic               w_wr_busy;
    logic               w_rd_busy;
    logic               w_wr_adv;
    logic               w_rd_adv;
    logic               w_wr_wrap;
    logic               w_rd_wrap_unused;
    logic [BCNT_W:0]    w_wr_addr;
    logic [BCNT_W:0]    w_rd_addr;

    assign w_wr_level = bus.wr_fifo_level;
    assign w_rd_level = bus.rd_fifo_level;

    // Write needs a full burst buffered; read needs a full burst of free space
    assign w_wr_elig   = bus.init_done && (32'(w_wr_level) >= 32'(BURST_LEN));
    assign w_rd_elig   = bus.init_done && r_rd_buf_valid
                         && (32'(w_rd_level) + 32'(BURST_LEN) <= 32'(RD_FIFO_DEPTH));
    assign w_rd_urgent = (32'(w_rd_level) < 32'(RD_URGENT));

    assign w_wr_busy = (r_state == ST_WR_BUSY);
    assign w_rd_busy = (r_state == ST_RD_BUSY);
    assign w_wr_adv  = w_wr_busy && bus.wr_sdram_ack;
    assign w_rd_adv  = w_rd_busy && bus.rd_sdram_ack;

    // IDLE arbitration: urgent read first, otherwise round-robin against the last grant
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_wr_elig && w_rd_elig) begin
                if (w_rd_urgent || (r_last_grant == GNT_WR)) begin
                    w_grant_rd = 1'b1;
                end else begin
                    w_grant_wr = 1'b1;
                end
            end else begin
                w_grant_wr = w_wr_elig;
                w_grant_rd = w_rd_elig;
            end
        end
    end

    // FSM, grant history and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_last_grant    <= GNT_RD;
            r_completed_buf <= 1'b0;
            r_rd_buf_valid  <= 1'b0;
            r_wr_frame_done <= 1'b0;
        end else begin
            r_wr_frame_done <= w_wr_wrap;
            if (w_wr_wrap) begin
                r_rd_buf_valid  <= 1'b1;
                r_completed_buf <= w_wr_addr[BCNT_W];
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_wr) begin
                        r_state <= ST_WR_BUSY;
                    end else if (w_grant_rd) begin
                        r_state <= ST_RD_BUSY;
                    end
                end
                ST_WR_BUSY: begin
                    if (bus.wr_sdram_ack) begin
                        r_state      <= ST_GAP;
                        r_last_grant <= GNT_WR;
                    end
                end
                ST_RD_BUSY: begin
                    if (bus.rd_sdram_ack) begin
                        r_state      <= ST_GAP;
                        r_last_grant <= GNT_RD;
                    end
                end
                default: begin
                    // GAP: keeps requests low for a cycle so the controller sees idle
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    burst_addr_gen #(
        .FRAME_BURSTS   (FRAME_BURSTS),
        .BCNT_W         (BCNT_W),
        .TOGGLE_ON_WRAP (1'b1),
        .LOAD_ON_START  (1'b0)
    ) u_wr_addr (
        .clk           (clk),
        .rst           (rst),
        .i_busy        (w_wr_busy),
        .i_adv         (w_wr_adv),
        .i_frame_start (bus.wr_frame_start),
        .i_load_buf    (1'b0),
        .o_addr        (w_wr_addr),
        .o_wrap        (w_wr_wrap)
    );

    burst_addr_gen #(
        .FRAME_BURSTS   (FRAME_BURSTS),
        .BCNT_W         (BCNT_W),
        .TOGGLE_ON_WRAP (1'b0),
        .LOAD_ON_START  (1'b1)
    ) u_rd_addr (
        .clk           (clk),
        .rst           (rst),
        .i_busy        (w_rd_busy),
        .i_adv         (w_rd_adv),
        .i_frame_start (bus.rd_frame_start),
        .i_load_buf    (r_completed_buf),
        .o_addr        (w_rd_addr),
        .o_wrap        (w_rd_wrap_unused)
    );

    assign bus.wr_sdram_req  = w_wr_busy;
    assign bus.rd_sdram_req  = w_rd_busy;
    assign bus.wr_burst_addr = w_wr_addr;
    assign bus.rd_burst_addr = w_rd_addr;
    assign bus.rd_buf_valid  = r_rd_buf_valid;
    assign bus.wr_frame_done = r_wr_frame_done;
endmodule
